// File: rtl/pipelined_addsub_pass_through.sv
// Segmented, carry-linked add/subtract pipeline with a sideband tag and stall-all valid/ready control.
// One SEG-bit slice is summed per stage; the partial result is shifted in from the top so it lands aligned at the output.
module pipelined_addsub_pass_through #(
    parameter int SIZE              = 32,
    parameter int STAGES            = 4,
    parameter int PASS_THROUGH_SIZE = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    output logic                         ready_out,
    input  logic                         sub,
    input  logic [SIZE-1:0]              input_1,
    input  logic [SIZE-1:0]              input_2,
    input  logic                         carry_in,
    input  logic [PASS_THROUGH_SIZE-1:0] passthrough_in,
    output logic [SIZE-1:0]              sum,
    output logic                         carry,
    output logic                         overflow,
    output logic                         load_out,
    input  logic                         ready_in,
    output logic [PASS_THROUGH_SIZE-1:0] passthrough_out
);

    localparam int SEG = SIZE / STAGES;

    logic                         r_valid [0:STAGES];
    logic [PASS_THROUGH_SIZE-1:0] r_tag   [0:STAGES];
    logic                         r_cy    [0:STAGES];
    logic                         r_amsb  [0:STAGES];
    logic                         r_bmsb  [0:STAGES];
    logic [SIZE-1:0]              r_a     [0:STAGES-1];
    logic [SIZE-1:0]              r_b     [0:STAGES-1];
    logic [SIZE-1:0]              r_sum   [1:STAGES];

    logic [SIZE-1:0] w_sum_next [1:STAGES];
    logic            w_cy_next  [1:STAGES];
    logic [SIZE-1:0] w_b_mod;
    logic            w_advance;
    logic            w_accept;

    assign w_advance = !r_valid[STAGES] || ready_in;
    assign w_accept  = load && w_advance;
    assign w_b_mod   = sub ? ~input_2 : input_2;

    genvar gi;
    generate
        for (gi = 1; gi <= STAGES; gi++) begin : g_stage
            logic [SEG:0] w_seg;
            // Remaining operands are pre-shifted, so the live slice is always the low SEG bits.
            assign w_seg = {1'b0, r_a[gi-1][SEG-1:0]} + {1'b0, r_b[gi-1][SEG-1:0]}
                         + {{SEG{1'b0}}, r_cy[gi-1]};
            assign w_cy_next[gi] = w_seg[SEG];
            if (STAGES == 1) begin : g_full
                assign w_sum_next[gi] = w_seg[SEG-1:0];
            end else if (gi == 1) begin : g_first
                assign w_sum_next[gi] = {w_seg[SEG-1:0], {(SIZE-SEG){1'b0}}};
            end else begin : g_rest
                assign w_sum_next[gi] = {w_seg[SEG-1:0], r_sum[gi-1][SIZE-1:SEG]};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_tag[k]   <= '0;
                r_cy[k]    <= 1'b0;
                r_amsb[k]  <= 1'b0;
                r_bmsb[k]  <= 1'b0;
            end
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            for (int k = 1; k <= STAGES; k++) begin
                r_sum[k] <= '0;
            end
        end else if (w_advance) begin
            r_valid[0] <= w_accept;
            if (w_accept) begin
                r_a[0]    <= input_1;
                r_b[0]    <= w_b_mod;
                r_cy[0]   <= carry_in ^ sub;
                r_tag[0]  <= passthrough_in;
                r_amsb[0] <= input_1[SIZE-1];
                r_bmsb[0] <= w_b_mod[SIZE-1];
            end
            // Data only moves with a valid operation so the output keeps its last result across bubbles.
            for (int k = 1; k <= STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
                if (r_valid[k-1]) begin
                    r_sum[k]  <= w_sum_next[k];
                    r_cy[k]   <= w_cy_next[k];
                    r_tag[k]  <= r_tag[k-1];
                    r_amsb[k] <= r_amsb[k-1];
                    r_bmsb[k] <= r_bmsb[k-1];
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (r_valid[k-1]) begin
                    r_a[k] <= r_a[k-1] >> SEG;
                    r_b[k] <= r_b[k-1] >> SEG;
                end
            end
        end
    end

    assign ready_out       = w_advance;
    assign load_out        = r_valid[STAGES];
    assign sum             = r_sum[STAGES];
    assign carry           = r_cy[STAGES];
    assign passthrough_out = r_tag[STAGES];
    assign overflow        = (r_amsb[STAGES] == r_bmsb[STAGES])
                          && (r_sum[STAGES][SIZE-1] != r_amsb[STAGES]);

endmodule

// File: tb/tb_pipelined_addsub_pass_through.sv
// Directed and random stimulus against a queue-based scoreboard for the pipelined add/subtract block.
module tb_pipelined_addsub_pass_through;

    localparam int SIZE   = 32;
    localparam int STAGES = 4;
    localparam int PT     = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load = 1'b0;
    logic            sub = 1'b0;
    logic            carry_in = 1'b0;
    logic            ready_in = 1'b1;
    logic [SIZE-1:0] input_1 = '0;
    logic [SIZE-1:0] input_2 = '0;
    logic [PT-1:0]   passthrough_in = '0;
    logic            ready_out;
    logic [SIZE-1:0] sum;
    logic            carry;
    logic            overflow;
    logic            load_out;
    logic [PT-1:0]   passthrough_out;

    pipelined_addsub_pass_through #(
        .SIZE(SIZE), .STAGES(STAGES), .PASS_THROUGH_SIZE(PT)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .ready_out(ready_out),
        .sub(sub), .input_1(input_1), .input_2(input_2), .carry_in(carry_in),
        .passthrough_in(passthrough_in), .sum(sum), .carry(carry),
        .overflow(overflow), .load_out(load_out), .ready_in(ready_in),
        .passthrough_out(passthrough_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SIZE-1:0] sum;
        logic            carry;
        logic            ovf;
        logic [PT-1:0]   tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int n_out = 0;
    int run_len = 0;
    int cyc = 0;
    int last_xfer = -10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                   input logic s, input logic cin, input logic [PT-1:0] t);
        exp_t        e;
        logic [33:0] w;
        longint      sa;
        longint      sbv;
        longint      r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (!s) begin
            w       = {2'b00, a} + {2'b00, b} + 34'(cin);
            e.sum   = w[31:0];
            e.carry = w[32];
            r       = sa + sbv + longint'(cin);
        end else begin
            e.sum   = a - b - 32'(cin);
            e.carry = ({1'b0, a} >= ({1'b0, b} + 33'(cin)));
            r       = sa - sbv - longint'(cin);
        end
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.tag = t;
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
        end else begin
            if (load_out && ready_in) begin
                if (sb.size() == 0) begin
                    check("pending_before_output", 64'(sb.size() > 0), 64'(1));
                end else begin
                    e = sb.pop_front();
                    $display("out  tag=%h sum=%h carry=%0d ovf=%0d", passthrough_out, sum, carry, overflow);
                    check("sb_sum", 64'(sum), 64'(e.sum));
                    check("sb_carry", 64'(carry), 64'(e.carry));
                    check("sb_overflow", 64'(overflow), 64'(e.ovf));
                    check("sb_tag", 64'(passthrough_out), 64'(e.tag));
                end
                n_out++;
                run_len = (last_xfer == cyc - 1) ? run_len + 1 : 1;
                last_xfer = cyc;
            end
            if (load && ready_out) begin
                $display("in   tag=%h a=%h b=%h sub=%0d cin=%0d", passthrough_in, input_1, input_2, sub, carry_in);
                sb.push_back(model(input_1, input_2, sub, carry_in, passthrough_in));
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic s,
                        input logic c, input logic [PT-1:0] t, output int waited);
        input_1 = a; input_2 = b; sub = s; carry_in = c; passthrough_in = t; load = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (ready_out || waited > 100) break;
            waited++;
        end
        check("send_accept", 64'(ready_out), 64'(1));
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic wait_tag(input logic [PT-1:0] t);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (load_out && passthrough_out == t) found = 1'b1;
        end
        check("wait_tag", 64'(found), 64'(1));
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    function automatic logic [SIZE-1:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int w;
        logic [SIZE-1:0] s_hold;
        logic [PT-1:0]   t_hold;
        int n_before;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_load_out", 64'(load_out), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_carry", 64'(carry), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_tag", 64'(passthrough_out), 64'(0));
        check("rst_ready_out", 64'(ready_out), 64'(1));

        // Full ripple carry and exact latency.
        sync();
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 16'h00A5, w);
        for (int i = 0; i < STAGES; i++) begin
            @(negedge clk);
            check("latency_early", 64'(load_out), 64'(0));
        end
        @(negedge clk);
        check("latency_valid", 64'(load_out), 64'(1));
        check("ripple_sum", 64'(sum), 64'(0));
        check("ripple_carry", 64'(carry), 64'(1));
        check("ripple_ovf", 64'(overflow), 64'(0));
        check("ripple_tag", 64'(passthrough_out), 64'h00A5);

        // Subtract cases.
        sync();
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 16'h0001, w);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 16'h0002, w);
        wait_tag(16'h0001);
        check("sub_neg_sum", 64'(sum), 64'hFFFF_FFFE);
        check("sub_neg_carry", 64'(carry), 64'(0));
        wait_tag(16'h0002);
        check("sub_ovf_sum", 64'(sum), 64'h7FFF_FFFF);
        check("sub_ovf_ovf", 64'(overflow), 64'(1));
        check("sub_ovf_carry", 64'(carry), 64'(1));
        drain();

        // Back-to-back streaming.
        sync();
        n_before = n_out;
        for (int i = 0; i < 8; i++) begin
            send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'(16'h0100 + i), w);
            check("stream_ready_out", 64'(w), 64'(0));
        end
        drain();
        check("stream_count", 64'(n_out - n_before), 64'(8));
        check("stream_run", 64'(run_len), 64'(8));

        // Backpressure: freeze with the first result valid, ignore a new load.
        sync();
        ready_in = 1'b0;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 16'h0200, w);
        send(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 16'h0201, w);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 16'h0202, w);
        for (int n = 0; n < 20 && !load_out; n++) @(negedge clk);
        check("bp_valid", 64'(load_out), 64'(1));
        check("bp_first_tag", 64'(passthrough_out), 64'h0200);
        s_hold = sum;
        t_hold = passthrough_out;
        sync();
        input_1 = 32'hDEAD_BEEF; input_2 = 32'h1; sub = 1'b0; carry_in = 1'b0;
        passthrough_in = 16'h02FF; load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_out", 64'(ready_out), 64'(0));
            check("bp_load_out", 64'(load_out), 64'(1));
            check("bp_sum_frozen", 64'(sum), 64'(s_hold));
            check("bp_tag_frozen", 64'(passthrough_out), 64'(t_hold));
        end
        sync();
        load = 1'b0;
        ready_in = 1'b1;
        drain();
        check("bp_run", 64'(run_len), 64'(3));

        // Reset mid-flight discards everything.
        sync();
        send(32'h1, 32'h2, 1'b0, 1'b0, 16'h0301, w);
        send(32'h3, 32'h4, 1'b0, 1'b0, 16'h0302, w);
        send(32'h5, 32'h6, 1'b0, 1'b0, 16'h0303, w);
        reset = 1'b1;
        sync();
        reset = 1'b0;
        n_before = n_out;
        @(negedge clk);
        check("mid_rst_sum", 64'(sum), 64'(0));
        check("mid_rst_carry", 64'(carry), 64'(0));
        check("mid_rst_ovf", 64'(overflow), 64'(0));
        check("mid_rst_tag", 64'(passthrough_out), 64'(0));
        check("mid_rst_ready_out", 64'(ready_out), 64'(1));
        for (int i = 0; i < 8; i++) begin
            check("mid_rst_load_out", 64'(load_out), 64'(0));
            @(negedge clk);
        end
        check("mid_rst_no_output", 64'(n_out - n_before), 64'(0));

        // Random regression with random load and backpressure.
        sync();
        for (int i = 0; i < 400; i++) begin
            load           = 1'($urandom_range(0, 1));
            ready_in       = ($urandom_range(0, 3) != 0);
            sub            = 1'($urandom_range(0, 1));
            carry_in       = 1'($urandom_range(0, 1));
            input_1        = pick();
            input_2        = pick();
            passthrough_in = 16'(16'h1000 + i);
            sync();
        end
        load = 1'b0;
        ready_in = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
